bcd_counter_7seg: RTL and testbench

Single-digit decimal (BCD 0-9) counter with a direct seven-segment output.
- The `enter` strobe has two uses, selected by `mode`: it starts/stops counting, or it loads a preset digit from the `load` switches.
- Sits between debounced front-panel switches/buttons and one seven-segment display digit.

---
 rtl/bcd_counter_7seg.sv | 91 +++++++++
 tb/tb_bcd_counter_7seg.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_counter_7seg.sv
// Single-digit BCD counter (0-9) with a direct seven-segment decode.
// `enter` starts/stops counting in count mode (mode=0) or loads a preset digit
// in load mode (mode=1). Optional build macro BCD_COUNTER_SEG_ACTIVE_LOW_EN
// inverts the segment outputs for common-anode displays.
module bcd_counter_7seg #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic       clk,
  input  logic       rstn,   // synchronous, active-high despite the name
  input  logic [3:0] load,
  input  logic       mode,
  input  logic       enter,
  output logic [6:0] OUT
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PreMax = PW'(TICK_DIV - 1);

  logic [3:0]    r_digit, w_digit_d;
  logic          r_run, w_run_d;
  logic [PW-1:0] r_pre, w_pre_d;
  logic          r_enter_q;
  logic          w_enter_rise;
  logic [3:0]    w_digit_inc;
  logic [6:0]    w_seg;

  assign w_enter_rise = enter & ~r_enter_q;
  assign w_digit_inc  = (r_digit == 4'd9) ? 4'd0 : r_digit + 4'd1;

  // Next-state for digit, run flag and prescaler.
  always_comb begin
    w_digit_d = r_digit;
    w_run_d   = r_run;
    w_pre_d   = '0;
    if (mode) begin
      // Load mode: counting frozen, run preserved, out-of-range presets dropped.
      if (w_enter_rise && (load <= 4'd9)) begin
        w_digit_d = load;
      end
    end else if (w_enter_rise) begin
      // Start/stop edge never increments and restarts the prescale period.
      w_run_d = ~r_run;
    end else if (r_run) begin
      if (r_pre == PreMax) begin
        w_digit_d = w_digit_inc;
      end else begin
        w_pre_d = r_pre + 1'b1;
      end
    end
  end

  // State registers with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (rstn) begin
      r_digit   <= 4'd0;
      r_run     <= 1'b0;
      r_pre     <= '0;
      r_enter_q <= 1'b0;
    end else begin
      r_digit   <= w_digit_d;
      r_run     <= w_run_d;
      r_pre     <= w_pre_d;
      r_enter_q <= enter;
    end
  end

  // Segment decode, bit 0 = a ... bit 6 = g, active-high.
  always_comb begin
    w_seg = 7'h00;
    case (r_digit)
      4'd0: w_seg = 7'h3F;
      4'd1: w_seg = 7'h06;
      4'd2: w_seg = 7'h5B;
      4'd3: w_seg = 7'h4F;
      4'd4: w_seg = 7'h66;
      4'd5: w_seg = 7'h6D;
      4'd6: w_seg = 7'h7D;
      4'd7: w_seg = 7'h07;
      4'd8: w_seg = 7'h7F;
      4'd9: w_seg = 7'h6F;
      default: w_seg = 7'h00;
    endcase
  end

`ifdef BCD_COUNTER_SEG_ACTIVE_LOW_EN
  assign OUT = ~w_seg;
`else
  assign OUT = w_seg;
`endif

endmodule

// File: tb/tb_bcd_counter_7seg.sv
// Directed testbench for bcd_counter_7seg: one DUT with TICK_DIV=1 and one
// with TICK_DIV=4, sharing the same stimulus.
module tb_bcd_counter_7seg;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic [3:0] load = 4'd0;
  logic       mode = 1'b0;
  logic       enter = 1'b0;
  logic [6:0] out1, out4;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bcd_counter_7seg #(.TICK_DIV(1)) dut1 (
    .clk(clk), .rstn(rstn), .load(load), .mode(mode), .enter(enter), .OUT(out1)
  );

  bcd_counter_7seg #(.TICK_DIV(4)) dut4 (
    .clk(clk), .rstn(rstn), .load(load), .mode(mode), .enter(enter), .OUT(out4)
  );

  // Expected segment pattern for a digit, following the build polarity.
  function automatic logic [6:0] seg(input int d);
    logic [6:0] s;
    case (d)
      0: s = 7'h3F;
      1: s = 7'h06;
      2: s = 7'h5B;
      3: s = 7'h4F;
      4: s = 7'h66;
      5: s = 7'h6D;
      6: s = 7'h7D;
      7: s = 7'h07;
      8: s = 7'h7F;
      9: s = 7'h6F;
      default: s = 7'h00;
    endcase
`ifdef BCD_COUNTER_SEG_ACTIVE_LOW_EN
    s = ~s;
`endif
    return s;
  endfunction

  // Advance one rising edge and settle; inputs change only after this.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn  = 1'b1;
    load  = 4'($urandom_range(0, 15));
    mode  = 1'($urandom_range(0, 1));
    enter = 1'($urandom_range(0, 1));
    tick();
    tick();
    n_checks++;
    if (out1 !== seg(0)) begin
      n_errors++;
      $display("FAIL reset_out1: got %h expected %h", out1, seg(0));
    end
    n_checks++;
    if (out4 !== seg(0)) begin
      n_errors++;
      $display("FAIL reset_out4: got %h expected %h", out4, seg(0));
    end
    rstn  = 1'b0;
    enter = 1'b0;
    mode  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if (out1 !== seg(0)) begin
        n_errors++;
        $display("FAIL reset_hold cycle %0d: got %h expected %h", i, out1, seg(0));
      end
    end
  endtask

  task automatic test_start();
    int exp_d [10] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0};
    mode  = 1'b0;
    enter = 1'b1;
    tick();  // run set, no increment on this edge
    n_checks++;
    if (out1 !== seg(0)) begin
      n_errors++;
      $display("FAIL start_edge: got %h expected %h", out1, seg(0));
    end
    for (int i = 0; i < 10; i++) begin
      tick();  // enter still high on the first of these: no second toggle
      enter = 1'b0;
      n_checks++;
      if (out1 !== seg(exp_d[i])) begin
        n_errors++;
        $display("FAIL start_step %0d: got %h expected %h", i, out1, seg(exp_d[i]));
      end
    end
  endtask

  task automatic test_stop_hold();
    // Digit is 0 and running.
    tick(); tick(); tick();  // -> 3
    enter = 1'b1;
    tick();                  // stop, no increment
    enter = 1'b0;
    n_checks++;
    if (out1 !== seg(3)) begin
      n_errors++;
      $display("FAIL stop_edge: got %h expected %h", out1, seg(3));
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      n_checks++;
      if (out1 !== seg(3)) begin
        n_errors++;
        $display("FAIL stop_hold cycle %0d: got %h expected %h", i, out1, seg(3));
      end
    end
  endtask

  task automatic test_load();
    // Restart, then switch to load mode with run=1.
    enter = 1'b1;
    tick();                  // run=1, digit 3
    enter = 1'b0;
    mode  = 1'b1;
    tick();                  // load mode, frozen
    n_checks++;
    if (out1 !== seg(3)) begin
      n_errors++;
      $display("FAIL load_mode_switch: got %h expected %h", out1, seg(3));
    end
    load  = 4'b0101;
    enter = 1'b1;
    tick();
    enter = 1'b0;
    n_checks++;
    if (out1 !== seg(5)) begin
      n_errors++;
      $display("FAIL load_5: got %h expected %h", out1, seg(5));
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (out1 !== seg(5)) begin
        n_errors++;
        $display("FAIL load_frozen cycle %0d: got %h expected %h", i, out1, seg(5));
      end
    end
    mode = 1'b0;
    tick();
    n_checks++;
    if (out1 !== seg(6)) begin
      n_errors++;
      $display("FAIL load_resume1: got %h expected %h", out1, seg(6));
    end
    tick();
    n_checks++;
    if (out1 !== seg(7)) begin
      n_errors++;
      $display("FAIL load_resume2: got %h expected %h", out1, seg(7));
    end
  endtask

  task automatic test_invalid_load();
    mode = 1'b1;
    tick();                  // digit 7, frozen
    load  = 4'hC;
    enter = 1'b1;
    tick();
    enter = 1'b0;
    n_checks++;
    if (out1 !== seg(7)) begin
      n_errors++;
      $display("FAIL invalid_load_C: got %h expected %h", out1, seg(7));
    end
    tick();
    load  = 4'hF;
    enter = 1'b1;
    tick();
    enter = 1'b0;
    n_checks++;
    if (out1 !== seg(7)) begin
      n_errors++;
      $display("FAIL invalid_load_F: got %h expected %h", out1, seg(7));
    end
    tick();
    load  = 4'd9;            // highest legal preset
    enter = 1'b1;
    tick();
    enter = 1'b0;
    n_checks++;
    if (out1 !== seg(9)) begin
      n_errors++;
      $display("FAIL load_9: got %h expected %h", out1, seg(9));
    end
    mode = 1'b0;
    tick();                  // still running: 9 wraps to 0
    n_checks++;
    if (out1 !== seg(0)) begin
      n_errors++;
      $display("FAIL load_9_wrap: got %h expected %h", out1, seg(0));
    end
  endtask

  task automatic test_prescale_reset();
    rstn = 1'b1;
    tick();
    rstn = 1'b0;
    mode  = 1'b0;
    enter = 1'b1;
    tick();                  // start dut4, prescaler at 0
    enter = 1'b0;
    n_checks++;
    if (out4 !== seg(0)) begin
      n_errors++;
      $display("FAIL prescale_start: got %h expected %h", out4, seg(0));
    end
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_checks++;
      if (out4 !== seg(k / 4)) begin
        n_errors++;
        $display("FAIL prescale edge %0d: got %h expected %h", k, out4, seg(k / 4));
      end
    end
    tick(); tick();          // mid-period
    rstn = 1'b1;
    tick();
    rstn = 1'b0;
    n_checks++;
    if (out4 !== seg(0)) begin
      n_errors++;
      $display("FAIL midrun_reset4: got %h expected %h", out4, seg(0));
    end
    n_checks++;
    if (out1 !== seg(0)) begin
      n_errors++;
      $display("FAIL midrun_reset1: got %h expected %h", out1, seg(0));
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      n_checks++;
      if (out4 !== seg(0) || out1 !== seg(0)) begin
        n_errors++;
        $display("FAIL post_reset_stopped cycle %0d: got %h/%h expected %h",
                 i, out1, out4, seg(0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_stop_hold();
    test_load();
    test_invalid_load();
    test_prescale_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
